pong_ball_ctrl: RTL and testbench

PONG_BALL_CTRL -- requirements
Module: pong_ball_ctrl

---
 rtl/pong_pkg.sv | 34 +++
 rtl/frame_tick_gen.sv | 37 +++
 rtl/pong_ball_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and screen/paddle geometry for the pong ball controller
//
// Contents:
//   ball_state_t        - controller FSM state encoding
//   *_DEF localparams   - default screen, ball and paddle geometry
//   DX_MAX              - horizontal step ceiling used when speed-up is built in
//   sat_inc()           - saturating score increment
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_SCORED    = 2'd2,
        ST_GAME_OVER = 2'd3
    } ball_state_t;

    localparam int SCREEN_W_DEF     = 640;
    localparam int SCREEN_H_DEF     = 480;
    localparam int BALL_SIZE_DEF    = 10;
    localparam int PADDLE_W_DEF     = 10;
    localparam int PADDLE_H_DEF     = 80;
    localparam int P1_X_DEF         = 20;
    localparam int P2_X_DEF         = 610;
    localparam int SPEED_DEF        = 2;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int WIN_SCORE_DEF    = 9;
    localparam int DX_MAX           = 6;

    // Score increment that sticks at the limit once reached.
    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - one-cycle pulse on entry to the raster position (0, SCREEN_H)
//
// Ports:
//   i_clk        in   clock
//   i_reset      in   synchronous active-high reset
//   i_x_pix      in   raster x from the VGA driver
//   i_y_pix      in   raster y from the VGA driver
//   o_frame_tick out  high for the first cycle the raster sits at (0, SCREEN_H)
module frame_tick_gen
    import pong_pkg::*;
#(
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_x_pix,
    input  logic [9:0] i_y_pix,
    output logic       o_frame_tick
);

    logic w_at_blank;
    logic r_at_blank_d;

    assign w_at_blank = (i_x_pix == 10'd0) && (i_y_pix == 10'(SCREEN_H));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_at_blank_d <= 1'b0;
        end else begin
            r_at_blank_d <= w_at_blank;
        end
    end

    // Rising edge only: the raster may dwell on this position for several cycles.
    assign o_frame_tick = w_at_blank & ~r_at_blank_d;

endmodule

// File: rtl/pong_ball_ctrl.sv
// rtl/pong_ball_ctrl.sv - pong ball motion, paddle/wall collision, scoring and game FSM
//
// Optional feature macro: PONG_SPEEDUP_EN (each paddle hit raises dx by 1 up to DX_MAX;
// dx returns to SPEED on every serve). Without it dx stays at SPEED.
//
// Ports:
//   CLOCK_50            in   sole clock, rising edge
//   reset               in   synchronous active-high reset
//   X_pix, Y_pix        in   raster position from the VGA driver
//   p1_y, p2_y          in   paddle top-edge y
//   start               in   starts a new game from GAME_OVER
//   ball_x, ball_y      out  ball top-left corner
//   score_p1, score_p2  out  scores, saturating at WIN_SCORE
//   point_p1, point_p2  out  one-cycle scoring pulses
//   game_over           out  high while in GAME_OVER
module pong_ball_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int SCREEN_H     = SCREEN_H_DEF,
    parameter int BALL_SIZE    = BALL_SIZE_DEF,
    parameter int PADDLE_W     = PADDLE_W_DEF,
    parameter int PADDLE_H     = PADDLE_H_DEF,
    parameter int P1_X         = P1_X_DEF,
    parameter int P2_X         = P2_X_DEF,
    parameter int SPEED        = SPEED_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int WIN_SCORE    = WIN_SCORE_DEF
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] X_pix,
    input  logic [9:0] Y_pix,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_y,
    input  logic       start,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       point_p1,
    output logic       point_p2,
    output logic       game_over
);

    localparam logic [9:0]         C_CX         = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]         C_CY         = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0]         C_Y_MAX      = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]         C_X_P1       = 10'(P1_X + PADDLE_W);
    localparam logic [9:0]         C_X_P2       = 10'(P2_X - BALL_SIZE);
    localparam logic signed [10:0] C_BALL_S     = 11'(BALL_SIZE);
    localparam logic signed [10:0] C_P1_EDGE_S  = 11'(P1_X + PADDLE_W);
    localparam logic signed [10:0] C_P2_EDGE_S  = 11'(P2_X);
    localparam logic signed [10:0] C_SW_S       = 11'(SCREEN_W);
    localparam logic signed [10:0] C_SH_S       = 11'(SCREEN_H);
    localparam logic signed [10:0] C_DY_S       = 11'(SPEED);
    localparam logic [11:0]        C_BALL_U     = 12'(BALL_SIZE);
    localparam logic [11:0]        C_PH_U       = 12'(PADDLE_H);
    localparam logic [3:0]         C_SPEED      = 4'(SPEED);
    localparam logic [3:0]         C_WIN        = 4'(WIN_SCORE);
    localparam logic [15:0]        C_SERVE_LAST = 16'(SERVE_FRAMES - 1);

    ball_state_t r_state, w_state_nxt;
    logic [9:0]  r_ball_x, w_ball_x_nxt;
    logic [9:0]  r_ball_y, w_ball_y_nxt;
    logic        r_dir_x, w_dir_x_nxt;     // 1 = right
    logic        r_dir_y, w_dir_y_nxt;     // 1 = down
    logic [3:0]  r_dx, w_dx_nxt;
    logic [3:0]  r_score_p1, w_score_p1_nxt;
    logic [3:0]  r_score_p2, w_score_p2_nxt;
    logic        r_point_p1, w_point_p1_nxt;
    logic        r_point_p2, w_point_p2_nxt;
    logic [15:0] r_serve_cnt, w_serve_cnt_nxt;

    logic               w_frame_tick;
    logic signed [10:0] w_x_s, w_y_s, w_dx_s, w_nx, w_ny;
    logic [11:0]        w_by_u, w_p1_u, w_p2_u;
    logic               w_p1_overlap, w_p2_overlap;
    logic               w_p1_hit, w_p2_hit, w_miss_l, w_miss_r;
    logic               w_wall_top, w_wall_bot;
    logic [3:0]         w_dx_hit;

    frame_tick_gen #(
        .SCREEN_H (SCREEN_H)
    ) u_frame_tick (
        .i_clk        (CLOCK_50),
        .i_reset      (reset),
        .i_x_pix      (X_pix),
        .i_y_pix      (Y_pix),
        .o_frame_tick (w_frame_tick)
    );

    // Next position in 11-bit signed so a step past 0 reads as negative, not a 10-bit wrap.
    assign w_x_s  = signed'({1'b0, r_ball_x});
    assign w_y_s  = signed'({1'b0, r_ball_y});
    assign w_dx_s = signed'({7'd0, r_dx});
    assign w_nx   = r_dir_x ? (w_x_s + w_dx_s) : (w_x_s - w_dx_s);
    assign w_ny   = r_dir_y ? (w_y_s + C_DY_S) : (w_y_s - C_DY_S);

    // Vertical overlap uses 12 bits since paddle y plus height may exceed 10 bits.
    assign w_by_u       = {2'b00, r_ball_y};
    assign w_p1_u       = {2'b00, p1_y};
    assign w_p2_u       = {2'b00, p2_y};
    assign w_p1_overlap = (w_by_u + C_BALL_U > w_p1_u) && (w_by_u < w_p1_u + C_PH_U);
    assign w_p2_overlap = (w_by_u + C_BALL_U > w_p2_u) && (w_by_u < w_p2_u + C_PH_U);

    // Hits need the ball to be on the court side of the paddle face now, so a ball
    // already behind the paddle falls through to a miss.
    assign w_p1_hit = !r_dir_x && (w_nx <= C_P1_EDGE_S) && (w_x_s >= C_P1_EDGE_S) && w_p1_overlap;
    assign w_p2_hit =  r_dir_x && (w_nx + C_BALL_S >= C_P2_EDGE_S) &&
                       (w_x_s + C_BALL_S <= C_P2_EDGE_S) && w_p2_overlap;
    assign w_miss_l = !r_dir_x && !w_p1_hit && (w_nx <= 11'sd0);
    assign w_miss_r =  r_dir_x && !w_p2_hit && (w_nx + C_BALL_S >= C_SW_S);

    assign w_wall_top = !r_dir_y && (w_ny < 11'sd0);
    assign w_wall_bot =  r_dir_y && (w_ny + C_BALL_S >= C_SH_S);

`ifdef PONG_SPEEDUP_EN
    assign w_dx_hit = (r_dx >= 4'(DX_MAX)) ? 4'(DX_MAX) : r_dx + 4'd1;
`else
    assign w_dx_hit = C_SPEED;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_ball_x_nxt    = r_ball_x;
        w_ball_y_nxt    = r_ball_y;
        w_dir_x_nxt     = r_dir_x;
        w_dir_y_nxt     = r_dir_y;
        w_dx_nxt        = r_dx;
        w_score_p1_nxt  = r_score_p1;
        w_score_p2_nxt  = r_score_p2;
        w_point_p1_nxt  = 1'b0;
        w_point_p2_nxt  = 1'b0;
        w_serve_cnt_nxt = r_serve_cnt;

        case (r_state)
            ST_SERVE: begin
                w_ball_x_nxt = C_CX;
                w_ball_y_nxt = C_CY;
                if (w_frame_tick) begin
                    if (r_serve_cnt == C_SERVE_LAST) begin
                        w_state_nxt     = ST_PLAY;
                        w_serve_cnt_nxt = 16'd0;
                    end else begin
                        w_serve_cnt_nxt = r_serve_cnt + 16'd1;
                    end
                end
            end

            ST_PLAY: begin
                if (w_frame_tick) begin
                    if (w_wall_top) begin
                        w_ball_y_nxt = 10'd0;
                        w_dir_y_nxt  = 1'b1;
                    end else if (w_wall_bot) begin
                        w_ball_y_nxt = C_Y_MAX;
                        w_dir_y_nxt  = 1'b0;
                    end else begin
                        w_ball_y_nxt = w_ny[9:0];
                    end

                    // Direction is left untouched on a miss: the ball already travels
                    // toward the player who lost the point, which is the next serve direction.
                    if (w_p1_hit) begin
                        w_ball_x_nxt = C_X_P1;
                        w_dir_x_nxt  = 1'b1;
                        w_dx_nxt     = w_dx_hit;
                    end else if (w_p2_hit) begin
                        w_ball_x_nxt = C_X_P2;
                        w_dir_x_nxt  = 1'b0;
                        w_dx_nxt     = w_dx_hit;
                    end else if (w_miss_l || w_miss_r) begin
                        w_point_p2_nxt = w_miss_l;
                        w_point_p1_nxt = w_miss_r;
                        if (w_miss_l) w_score_p2_nxt = sat_inc(r_score_p2, C_WIN);
                        if (w_miss_r) w_score_p1_nxt = sat_inc(r_score_p1, C_WIN);
                        w_ball_x_nxt = C_CX;
                        w_ball_y_nxt = C_CY;
                        w_state_nxt  = ST_SCORED;
                    end else begin
                        w_ball_x_nxt = w_nx[9:0];
                    end
                end
            end

            ST_SCORED: begin
                w_ball_x_nxt    = C_CX;
                w_ball_y_nxt    = C_CY;
                w_serve_cnt_nxt = 16'd0;
                w_dx_nxt        = C_SPEED;
                if ((r_score_p1 == C_WIN) || (r_score_p2 == C_WIN)) begin
                    w_state_nxt = ST_GAME_OVER;
                end else begin
                    w_state_nxt = ST_SERVE;
                end
            end

            ST_GAME_OVER: begin
                w_ball_x_nxt = C_CX;
                w_ball_y_nxt = C_CY;
                if (start) begin
                    w_score_p1_nxt  = 4'd0;
                    w_score_p2_nxt  = 4'd0;
                    w_serve_cnt_nxt = 16'd0;
                    w_dx_nxt        = C_SPEED;
                    w_state_nxt     = ST_SERVE;
                end
            end

            default: begin
                w_state_nxt = ST_SERVE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= ST_SERVE;
            r_ball_x    <= C_CX;
            r_ball_y    <= C_CY;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_dx        <= C_SPEED;
            r_score_p1  <= 4'd0;
            r_score_p2  <= 4'd0;
            r_point_p1  <= 1'b0;
            r_point_p2  <= 1'b0;
            r_serve_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ball_x    <= w_ball_x_nxt;
            r_ball_y    <= w_ball_y_nxt;
            r_dir_x     <= w_dir_x_nxt;
            r_dir_y     <= w_dir_y_nxt;
            r_dx        <= w_dx_nxt;
            r_score_p1  <= w_score_p1_nxt;
            r_score_p2  <= w_score_p2_nxt;
            r_point_p1  <= w_point_p1_nxt;
            r_point_p2  <= w_point_p2_nxt;
            r_serve_cnt <= w_serve_cnt_nxt;
        end
    end

    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign score_p1  = r_score_p1;
    assign score_p2  = r_score_p2;
    assign point_p1  = r_point_p1;
    assign point_p2  = r_point_p2;
    assign game_over = (r_state == ST_GAME_OVER);

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb/tb_pong_ball_ctrl.sv - scoreboard bench for pong_ball_ctrl with a frame-level ball model
module tb_pong_ball_ctrl;

    localparam int CX = 315;
    localparam int CY = 235;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [9:0] X_pix, Y_pix, p1_y, p2_y;
    logic       start;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_p1, score_p2;
    logic       point_p1, point_p2, game_over;

    always #5 CLOCK_50 = ~CLOCK_50;

    pong_ball_ctrl dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .X_pix     (X_pix),
        .Y_pix     (Y_pix),
        .p1_y      (p1_y),
        .p2_y      (p2_y),
        .start     (start),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .point_p1  (point_p1),
        .point_p2  (point_p2),
        .game_over (game_over)
    );

    typedef struct {
        int x;
        int y;
        int s1;
        int s2;
        int pt1;
        int pt2;
        int go;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model state: 0 serve, 1 play, 2 game over (scored is folded into the miss frame).
    int m_state, m_x, m_y, m_dirx, m_diry, m_dx, m_cnt, m_s1, m_s2;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = CX; m_y = CY; m_dirx = 1; m_diry = 1;
        m_dx = 2; m_cnt = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_tick(input int py1, input int py2, output exp_t e);
        int nx, ny;
        bit scored;
        e.pt1 = 0; e.pt2 = 0; scored = 0;
        if (m_state == 0) begin
            m_cnt++;
            if (m_cnt == 60) begin m_state = 1; m_cnt = 0; end
        end else if (m_state == 1) begin
            nx = m_dirx ? m_x + m_dx : m_x - m_dx;
            ny = m_diry ? m_y + 2 : m_y - 2;
            if (!m_diry && ny < 0) begin ny = 0; m_diry = 1; end
            else if (m_diry && ny + 10 >= 480) begin ny = 470; m_diry = 0; end
            if (!m_dirx && nx <= 30 && m_x >= 30 && m_y + 10 > py1 && m_y < py1 + 80) begin
                nx = 30; m_dirx = 1;
`ifdef PONG_SPEEDUP_EN
                if (m_dx < 6) m_dx++;
`endif
            end else if (m_dirx && nx + 10 >= 610 && m_x + 10 <= 610 && m_y + 10 > py2 && m_y < py2 + 80) begin
                nx = 600; m_dirx = 0;
`ifdef PONG_SPEEDUP_EN
                if (m_dx < 6) m_dx++;
`endif
            end else if (!m_dirx && nx <= 0) begin
                e.pt2 = 1; scored = 1;
                if (m_s2 < 9) m_s2++;
            end else if (m_dirx && nx + 10 >= 640) begin
                e.pt1 = 1; scored = 1;
                if (m_s1 < 9) m_s1++;
            end
            if (scored) begin
                m_x = CX; m_y = CY; m_dx = 2; m_cnt = 0;
                m_state = (m_s1 == 9 || m_s2 == 9) ? 2 : 0;
            end else begin
                m_x = nx; m_y = ny;
            end
        end
        e.x = m_x; e.y = m_y; e.s1 = m_s1; e.s2 = m_s2; e.go = (m_state == 2) ? 1 : 0;
    endtask

    // mode 0: paddle tracks the ball, mode 1: paddle kept clear of the ball.
    function automatic int paddle_pos(input int mode);
        int p;
        if (mode == 0) begin
            p = m_y - 35;
            if (p < 0) p = 0;
            if (p > 400) p = 400;
        end else begin
            p = (m_y > 240) ? 0 : 400;
        end
        return p;
    endfunction

    task automatic do_frame(input int mode1, input int mode2);
        exp_t e, got_e;
        int hold;
        p1_y = 10'(paddle_pos(mode1));
        p2_y = 10'(paddle_pos(mode2));
        model_tick(int'(p1_y), int'(p2_y), e);
        sb_q.push_back(e);
        hold = $urandom_range(1, 4);
        X_pix = 10'd0; Y_pix = 10'd480;
        @(posedge CLOCK_50); #1;
        got_e = sb_q.pop_front();
        check("tick_x", int'(ball_x), got_e.x);
        check("tick_y", int'(ball_y), got_e.y);
        check("tick_s1", int'(score_p1), got_e.s1);
        check("tick_s2", int'(score_p2), got_e.s2);
        check("tick_pt1", int'(point_p1), got_e.pt1);
        check("tick_pt2", int'(point_p2), got_e.pt2);
        repeat (hold - 1) begin @(posedge CLOCK_50); #1; end
        X_pix = 10'd5; Y_pix = 10'd100;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        check("hold_x", int'(ball_x), got_e.x);
        check("hold_y", int'(ball_y), got_e.y);
        check("hold_pt1", int'(point_p1), 0);
        check("hold_pt2", int'(point_p2), 0);
        check("hold_go", int'(game_over), got_e.go);
    endtask

    task automatic check_reset_state();
        check("rst_x", int'(ball_x), CX);
        check("rst_y", int'(ball_y), CY);
        check("rst_s1", int'(score_p1), 0);
        check("rst_s2", int'(score_p2), 0);
        check("rst_pt1", int'(point_p1), 0);
        check("rst_pt2", int'(point_p2), 0);
        check("rst_go", int'(game_over), 0);
    endtask

    initial begin
        int guard;
        reset = 1'b1; start = 1'b0;
        X_pix = 10'd5; Y_pix = 10'd100; p1_y = 10'd200; p2_y = 10'd200;
        repeat (3) @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        model_reset();
        check_reset_state();

        // Serve: 60 frames at centre, then the first move right/down.
        repeat (60) do_frame(0, 0);
        check("serve_hold_x", int'(ball_x), 315);
        check("serve_hold_y", int'(ball_y), 235);
        do_frame(0, 0);
        check("first_move_x", int'(ball_x), 317);
        check("first_move_y", int'(ball_y), 237);

        // Rally with both paddles tracking: paddle hits and wall bounces.
        repeat (600) do_frame(0, 0);
        check("rally_s1", int'(score_p1), 0);
        check("rally_s2", int'(score_p2), 0);

        // Player 1 steps aside; player 2 takes the point.
        guard = 0;
        while (m_s2 == 0 && guard < 1500) begin do_frame(1, 0); guard++; end
        check("p2_point_s2", int'(score_p2), 1);
        check("p2_point_s1", int'(score_p1), 0);

        // Serve goes toward the loser (left).
        repeat (61) do_frame(0, 1);
        check("serve_left_x", int'(ball_x), 313);

        // Player 2 steps aside until player 1 reaches the winning score.
        guard = 0;
        while (m_state != 2 && guard < 5000) begin do_frame(0, 1); guard++; end
        check("win_s1", int'(score_p1), 9);
        check("win_go", int'(game_over), 1);
        check("win_x", int'(ball_x), CX);
        check("win_y", int'(ball_y), CY);
        repeat (3) do_frame(0, 1);

        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        m_state = 0; m_cnt = 0; m_dx = 2; m_s1 = 0; m_s2 = 0;
        check("start_s1", int'(score_p1), 0);
        check("start_s2", int'(score_p2), 0);
        check("start_go", int'(game_over), 0);

        // Into play, then reset coinciding with a frame tick.
        repeat (65) do_frame(0, 0);
        X_pix = 10'd0; Y_pix = 10'd480; reset = 1'b1;
        @(posedge CLOCK_50); #1;
        reset = 1'b0; X_pix = 10'd5; Y_pix = 10'd100;
        model_reset();
        check_reset_state();
        @(posedge CLOCK_50); #1;
        check("post_rst_x", int'(ball_x), CX);
        repeat (61) do_frame(0, 0);
        check("reserve_x", int'(ball_x), 317);
        check("reserve_y", int'(ball_y), 237);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
